// File: rtl/pyfive_wb_uart_pkg.sv
// pyfive_wb_uart shared definitions:
// register offsets, STATUS bit indices, FSM states.
package pyfive_wb_uart_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;
  localparam logic [1:0] UART_REG_IRQ    = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_FRM_ERR  = 5;
  localparam int ST_TX_BUSY  = 6;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/pyfive_wb_uart_fifo.sv
// pyfive_fifo: synchronous FIFO, power-of-two DEPTH.
// A pop frees the slot for a same-cycle push when full.
module pyfive_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally, count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/pyfive_wb_uart.sv
// pyfive_wb_uart: Wishbone classic 8N1 UART with FIFOs.
// Optional IRQ output/register under PYFIVE_UART_IRQ_EN.
module pyfive_wb_uart
  import pyfive_wb_uart_pkg::*;
#(
  parameter int               FIFO_DEPTH = 16,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd867
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        uart_rx,
  output logic        uart_tx
`ifdef PYFIVE_UART_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [1:0]       reg_sel;
  logic             sel_data, sel_stat, sel_div, sel_irq;
  logic             access, wr, rd;
  logic [31:0]      rdata, status;
  logic [DIV_W-1:0] div_q;
  logic             ovr_q, ferr_q, rd_pop_q;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_dout;
  logic [CW-1:0]    tx_count;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_dout;
  logic [CW-1:0]    rx_count;
  logic             ovr_set, ferr_set;

  uart_state_t      tx_st, tx_st_n;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_sh, tx_sh_n;

  uart_state_t      rx_st, rx_st_n;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_sh, rx_sh_n;
  logic             rx_s1, rx_s2, rx_q;
  logic [DIV_W:0]   rx_half;

  assign clk      = wb_clk_i;
  assign rst      = wb_rst_i;
  assign reg_sel  = wbs_adr_i[3:2];
  assign sel_data = (reg_sel == UART_REG_DATA);
  assign sel_stat = (reg_sel == UART_REG_STATUS);
  assign sel_div  = (reg_sel == UART_REG_DIV);
  assign sel_irq  = (reg_sel == UART_REG_IRQ);
  assign access   = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign wr       = access && wbs_we_i;
  assign rd       = access && !wbs_we_i;
  assign tx_push  = wr && sel_data;
  assign rx_pop   = rd_pop_q;
  assign ovr_set  = rx_push && rx_full && !rx_pop;

  pyfive_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push(tx_push), .pop(tx_pop),
    .din(wbs_dat_i[7:0]), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  pyfive_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push(rx_push), .pop(rx_pop),
    .din(rx_sh_n), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // status word assembly
  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_OVR]   = ovr_q;
    status[ST_FRM_ERR]  = ferr_q;
    status[ST_TX_BUSY]  = (tx_st != UART_IDLE);
  end

`ifdef PYFIVE_UART_IRQ_EN
  logic [2:0] irq_en_q;
`endif

  // read mux
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_data: if (!rx_empty) rdata = {23'b0, 1'b1, rx_dout};
      sel_stat: rdata = status;
      sel_div:  rdata[DIV_W-1:0] = div_q;
      sel_irq: begin
`ifdef PYFIVE_UART_IRQ_EN
        rdata[2:0] = irq_en_q;
`endif
      end
      default: rdata = '0;
    endcase
  end

  // bus ack and registered read data; DATA pops on the ack cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      rd_pop_q  <= 1'b0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= rd ? rdata : '0;
      rd_pop_q  <= rd && sel_data && !rx_empty;
    end
  end

  // divider and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DIV_RESET;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (wr && sel_div) div_q <= wbs_dat_i[DIV_W-1:0];
      ovr_q  <= (ovr_q && !(wr && sel_stat && wbs_dat_i[ST_RX_OVR]))
              || ovr_set;
      ferr_q <= (ferr_q && !(wr && sel_stat && wbs_dat_i[ST_FRM_ERR]))
              || ferr_set;
    end
  end

`ifdef PYFIVE_UART_IRQ_EN
  // interrupt enable register and registered irq
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (wr && sel_irq) irq_en_q <= wbs_dat_i[2:0];
      irq_o <= |(irq_en_q & {ovr_q | ferr_q, tx_empty, !rx_empty});
    end
  end
`endif

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st  <= UART_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh  <= tx_sh_n;
    end
  end

  // TX next state; divider is reloaded only at bit boundaries
  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt - DIV_W'(1);
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_pop   = 1'b0;
    unique case (tx_st)
      UART_IDLE: begin
        tx_cnt_n = div_q;
        if (!tx_empty) begin
          tx_st_n = UART_START;
          tx_pop  = 1'b1;
          tx_sh_n = tx_dout;
        end
      end
      UART_START: if (tx_cnt == '0) begin
        tx_st_n  = UART_DATA;
        tx_cnt_n = div_q;
        tx_bit_n = '0;
      end
      UART_DATA: if (tx_cnt == '0) begin
        tx_cnt_n = div_q;
        tx_sh_n  = {1'b0, tx_sh[7:1]};
        tx_bit_n = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_st_n = UART_STOP;
      end
      UART_STOP: if (tx_cnt == '0) begin
        tx_cnt_n = div_q;
        if (!tx_empty) begin
          tx_st_n = UART_START;
          tx_pop  = 1'b1;
          tx_sh_n = tx_dout;
        end else begin
          tx_st_n = UART_IDLE;
        end
      end
      default: tx_st_n = UART_IDLE;
    endcase
  end

  assign uart_tx = (tx_st == UART_START) ? 1'b0 :
                   (tx_st == UART_DATA)  ? tx_sh[0] : 1'b1;

  // RX synchroniser and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st  <= UART_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  assign rx_half = ({1'b0, div_q} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

  // RX next state; mid-bit sampling after a half-period start check
  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt - DIV_W'(1);
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    unique case (rx_st)
      UART_IDLE: begin
        rx_cnt_n = rx_half[DIV_W-1:0];
        if (rx_q && !rx_s2) rx_st_n = UART_START;
      end
      UART_START: if (rx_cnt == '0) begin
        rx_cnt_n = div_q;
        rx_bit_n = '0;
        rx_st_n  = rx_s2 ? UART_IDLE : UART_DATA;
      end
      UART_DATA: if (rx_cnt == '0) begin
        rx_cnt_n = div_q;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_st_n = UART_STOP;
      end
      UART_STOP: if (rx_cnt == '0) begin
        rx_st_n  = UART_IDLE;
        rx_push  = rx_s2;
        ferr_set = !rx_s2;
      end
      default: rx_st_n = UART_IDLE;
    endcase
  end

  logic unused;
  assign unused = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i,
                    tx_count, rx_count, rx_half[DIV_W]};

endmodule

// File: tb/tb_pyfive_wb_uart.sv
// tb_pyfive_wb_uart: directed vectors for pyfive_wb_uart.
// Default build (no IRQ feature).
module tb_pyfive_wb_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [3:0]  adr;
  logic [31:0] dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        rx_drv, tx, loop;
  logic        rx_line;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] q;
  logic [7:0]  b;
  logic [9:0]  fr;
  int          n;

  assign rx_line = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  pyfive_wb_uart dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i(we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .uart_rx(rx_line),
    .uart_tx(tx)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic w, input logic [1:0] r,
                      input logic [31:0] d, output logic [31:0] rq);
    logic got;
    got = 1'b0;
    rq  = '0;
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = {r, 2'b00}; dat_i = d;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack) begin
        got = 1'b1;
        rq  = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack seen", {31'b0, got}, 32'd1);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, r, d, dummy);
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] rq);
    xfer(1'b0, r, 32'h0, rq);
  endtask

  task automatic wait_tx_low();
    for (int i = 0; i < 2000 && tx !== 1'b0; i++) tick();
    check("tx start found", {31'b0, tx}, 32'd0);
  endtask

  // decode one TX frame with bit period p, starting from idle/stop
  task automatic get_tx(input int p, output logic [7:0] v);
    wait_tx_low();
    repeat (p + p / 2) tick();
    for (int k = 0; k < 8; k++) begin
      v[k] = tx;
      repeat (p) tick();
    end
    check("tx stop bit", {31'b0, tx}, 32'd1);
  endtask

  // drive one RX frame with bit period p
  task automatic send_rx(input logic [7:0] v, input logic stopb,
                         input int p);
    rx_drv = 1'b0;
    repeat (p) tick();
    for (int k = 0; k < 8; k++) begin
      rx_drv = v[k];
      repeat (p) tick();
    end
    rx_drv = stopb;
    repeat (p) tick();
    rx_drv = 1'b1;
    repeat (p) tick();
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'hF; adr = '0; dat_i = '0;
    rx_drv = 1'b1; loop = 1'b0;
    repeat (3) tick();
    check("reset ack", {31'b0, ack}, 32'd0);
    check("reset dat_o", dat_o, 32'd0);
    check("reset tx", {31'b0, tx}, 32'd1);
    rst = 1'b0;
    tick();

    rd(2'd1, q); check("reset status", q, 32'h6);
    rd(2'd2, q); check("reset divider", q, 32'd867);
    rd(2'd0, q); check("empty data read", q, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, q); check("adr3 reads 0", q, 32'h0);

    // ack cadence with stb held high
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h4; n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n += int'(ack);
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack every other cycle", n, 32'd2);
    tick();

    // single frame 0xA5 at 4 clocks per bit
    wr(2'd2, 32'd3);
    wr(2'd0, 32'hA5);
    wait_tx_low();
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      check($sformatf("tx A5 clk %0d", i), {31'b0, tx},
            {31'b0, fr[i / 4]});
      tick();
    end
    rd(2'd1, q); check("tx idle after frame", q, 32'h6);

    // TX FIFO fill with a slow frame in flight
    wr(2'd2, 32'h3FF);
    wr(2'd0, 32'hFF);
    for (int i = 0; i < 16; i++) wr(2'd0, 32'h10 + i);
    rd(2'd1, q); check("tx full after 16", q, 32'h45);
    wr(2'd0, 32'h99);
    rd(2'd1, q); check("tx full after drop", q, 32'h45);
    wr(2'd2, 32'd1);
    for (int i = 0; i < 2000 && tx !== 1'b1; i++) tick();
    check("filler data high", {31'b0, tx}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      get_tx(2, b);
      check($sformatf("tx order %0d", i), {24'b0, b}, 32'h10 + i);
    end
    repeat (30) tick();
    rd(2'd1, q); check("tx drained, 17th dropped", q, 32'h6);

    // loopback 0x3C at 8 clocks per bit
    loop = 1'b1;
    wr(2'd2, 32'd7);
    wr(2'd0, 32'h3C);
    q = 32'h4;
    for (int i = 0; i < 100 && q[2]; i++) rd(2'd1, q);
    check("loopback rx_empty", {31'b0, q[2]}, 32'd0);
    rd(2'd0, q); check("loopback data", q, 32'h13C);
    rd(2'd0, q); check("loopback second read", q, 32'h0);
    repeat (20) tick();
    loop = 1'b0;
    tick();

    // framing error and W1C
    send_rx(8'h55, 1'b0, 8);
    rd(2'd1, q); check("frame_err set", q, 32'h26);
    wr(2'd1, 32'h20);
    rd(2'd1, q); check("frame_err cleared", q, 32'h6);

    // RX FIFO overrun
    for (int i = 0; i < 16; i++) send_rx(8'h40 + 8'(i), 1'b1, 8);
    rd(2'd1, q); check("rx full after 16", q, 32'h0A);
    send_rx(8'h77, 1'b1, 8);
    rd(2'd1, q); check("rx overrun", q, 32'h1A);
    for (int i = 0; i < 16; i++) begin
      rd(2'd0, q);
      check($sformatf("rx order %0d", i), q, 32'h140 + i);
    end
    rd(2'd0, q); check("rx 17th dropped", q, 32'h0);
    rd(2'd1, q); check("overrun sticky", q, 32'h16);
    wr(2'd1, 32'h10);
    rd(2'd1, q); check("overrun cleared", q, 32'h6);

    // reset mid-frame
    wr(2'd2, 32'd7);
    wr(2'd0, 32'h00);
    wait_tx_low();
    rst = 1'b1;
    tick();
    check("mid-frame reset tx", {31'b0, tx}, 32'd1);
    rst = 1'b0;
    tick();
    rd(2'd2, q); check("divider after reset", q, 32'd867);
    rd(2'd1, q); check("status after reset", q, 32'h6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
